countdown_timer: RTL and testbench
==================================

// Module: countdown_timer
// PURPOSE
//  Seconds countdown downstream of the 1 Hz divider. Loads a seconds value on
//  start_timer, decrements once per one_hz_enable tick, and pulses expired at zero.
//  Drives divider_restart back to the divider so the first counted second is full
//  length. Consumed by the alarm FSM, which supplies value and start_timer.
// PARAMETERS
//  W           4   width of value/remaining in seconds (max load 2^W-1)
// PORTS
//  clock            in   1  system clock (27 MHz)
//  reset_n          in   1  asynchronous active-low reset
//  start_timer      in   1  load request, 1-cycle pulse from FSM
//  value            in   W  seconds to load, sampled when start_timer=1
//  abort            in   1  cancel a running countdown
//  one_hz_enable    in   1  1-cycle tick from divider, once per second
//  divider_restart  out  1  1-cycle pulse to divider's start_timer input
//  remaining        out  W  seconds left (registered)
//  busy             out  1  high while counting
//  expired          out  1  1-cycle pulse when count reaches zero
// BEHAVIOUR
//  - One clock domain; all outputs registered; one_hz_enable assumed synchronous.
//  - Reset (reset_n=0, async): state=IDLE, remaining=0, busy=0, expired=0,
//    divider_restart=0. Reset mid-count discards the count, no expired pulse.
//  - States: IDLE, COUNT, DONE. busy=1 only in COUNT; expired=1 only in DONE.
//  - start_timer=1 at edge k, any state: remaining<=value, divider_restart=1 for
//    exactly cycle k..k+1; next state COUNT if value!=0, else DONE
//    (expired high during cycle after edge k, no ticks consumed).
//  - COUNT, one_hz_enable=1, no start/abort:
//      remaining>1  -> remaining<=remaining-1, stay COUNT
//      remaining==1 -> remaining<=0, go DONE
//  - DONE lasts exactly one cycle, then IDLE unless start_timer reloads.
//  - one_hz_enable ignored in IDLE and DONE; no wrap-around below 0.
//  - abort=1 in COUNT: go IDLE, remaining<=0, no expired pulse.
//    abort in IDLE/DONE: no effect (DONE still emits its expired pulse).
//  - Priority on the same edge: start_timer > abort > one_hz_enable.
//    start coincident with a tick: tick dropped, value loaded unchanged.
//  - Latency: N-second load expires on the edge sampling the Nth tick after
//    start; expired visible in the following cycle.
//  - divider_restart is never asserted except on a start_timer load.
// TESTING
//  1. Load 5, ticks every 10 cycles -> remaining 5,4,3,2,1,0; expired pulses
//     exactly 1 cycle after 5th tick; busy falls with it; state then IDLE.
//  2. Load 9, after 4 ticks start_timer with value=3 -> remaining=3,
//     divider_restart 1-cycle pulse, expired only after 3 further ticks.
//  3. Load value=0 -> no busy, expired pulse in next cycle, divider_restart pulses.
//  4. Load 6, abort after 2 ticks -> remaining=0, IDLE, no expired pulse;
//     subsequent ticks leave remaining=0.
//  5. Load 4, drop reset_n between ticks -> outputs 0 immediately (async),
//     no expired after reset release despite continued ticks.
//  6. start_timer(value=2) same cycle as one_hz_enable, and abort+start together
//     -> load wins, remaining=2, tick ignored; expired after two later ticks.

Source files
------------

// File: rtl/countdown_timer_if.sv
// ------------------------------------------------------------------
// countdown_timer_if: control/status bundle between alarm FSM and timer.
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

interface countdown_timer_if #(
  parameter int W = 4
);
  logic         start_timer;
  logic [W-1:0] value;
  logic         abort;
  logic         one_hz_enable;
  logic         divider_restart;
  logic [W-1:0] remaining;
  logic         busy;
  logic         expired;

  modport master (
    output start_timer, value, abort, one_hz_enable,
    input  divider_restart, remaining, busy, expired
  );

  modport slave (
    input  start_timer, value, abort, one_hz_enable,
    output divider_restart, remaining, busy, expired
  );
endinterface

`default_nettype wire

// File: rtl/countdown_timer.sv
// ------------------------------------------------------------------
// countdown_timer: loadable seconds countdown stepped by a 1 Hz enable.
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module countdown_timer #(
  parameter int W = 4
) (
  input  logic               clock,
  input  logic               reset_n,
  countdown_timer_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e       state_q, state_d;
  logic [W-1:0] remaining_q, remaining_d;
  logic         busy_q, busy_d;
  logic         expired_q, expired_d;
  logic         divider_restart_q, divider_restart_d;

  always_comb begin
    state_d           = state_q;
    remaining_d       = remaining_q;
    divider_restart_d = 1'b0;

    // A load wins over abort and tick regardless of the current state.
    if (bus.start_timer) begin
      remaining_d       = bus.value;
      divider_restart_d = 1'b1;
      state_d           = (bus.value != '0) ? COUNT : DONE;
    end else begin
      case (state_q)
        IDLE: ;
        COUNT: begin
          if (bus.abort) begin
            state_d     = IDLE;
            remaining_d = '0;
          end else if (bus.one_hz_enable) begin
            if (remaining_q > W'(1)) begin
              remaining_d = remaining_q - W'(1);
            end else begin
              remaining_d = '0;
              state_d     = DONE;
            end
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    busy_d    = (state_d == COUNT);
    expired_d = (state_d == DONE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q           <= IDLE;
      remaining_q       <= '0;
      busy_q            <= 1'b0;
      expired_q         <= 1'b0;
      divider_restart_q <= 1'b0;
    end else begin
      state_q           <= state_d;
      remaining_q       <= remaining_d;
      busy_q            <= busy_d;
      expired_q         <= expired_d;
      divider_restart_q <= divider_restart_d;
    end
  end

  assign bus.remaining       = remaining_q;
  assign bus.busy            = busy_q;
  assign bus.expired         = expired_q;
  assign bus.divider_restart = divider_restart_q;

endmodule

`default_nettype wire

// File: tb/tb_countdown_timer.sv
// ------------------------------------------------------------------
// tb_countdown_timer: directed stimulus with a cycle-stamped scoreboard.
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_countdown_timer;
  localparam int W = 4;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  countdown_timer_if #(.W(W)) bus ();

  countdown_timer #(.W(W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  typedef struct {
    int           cyc;
    int           tid;
    logic [W-1:0] rem;
    logic         busy;
    logic         exp;
    logic         drs;
  } exp_t;

  exp_t sb_q[$];
  int   cyc      = 0;
  int   checks   = 0;
  int   failures = 0;
  int   tid      = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: compares stamped entries; any pulse without an entry is an error.
  always @(negedge clock) begin : monitor
    exp_t e;
    while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
      e = sb_q.pop_front();
      checks++;
      failures++;
      $display("FAIL missed_t%0d actual cyc=%0d required cyc=%0d", e.tid, cyc, e.cyc);
    end
    if (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
      e = sb_q.pop_front();
      checks++;
      if ({bus.remaining, bus.busy, bus.expired, bus.divider_restart} !==
          {e.rem, e.busy, e.exp, e.drs}) begin
        failures++;
        $display("FAIL t%0d_cyc%0d actual rem=%0d busy=%b expired=%b restart=%b required rem=%0d busy=%b expired=%b restart=%b",
                 e.tid, cyc, bus.remaining, bus.busy, bus.expired, bus.divider_restart,
                 e.rem, e.busy, e.exp, e.drs);
      end
    end else begin
      checks++;
      if (bus.expired !== 1'b0 || bus.divider_restart !== 1'b0) begin
        failures++;
        $display("FAIL unexpected_pulse cyc=%0d actual expired=%b restart=%b required expired=0 restart=0",
                 cyc, bus.expired, bus.divider_restart);
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic expect_at(input int off, input int rem, input logic b, input logic e, input logic d);
    exp_t x;
    x.cyc  = cyc + off;
    x.tid  = tid;
    x.rem  = rem[W-1:0];
    x.busy = b;
    x.exp  = e;
    x.drs  = d;
    sb_q.push_back(x);
  endtask

  task automatic load(input int v, input logic b, input logic e);
    bus.start_timer = 1'b1;
    bus.value       = v[W-1:0];
    expect_at(1, v, b, e, 1'b1);
    step();
    bus.start_timer = 1'b0;
  endtask

  task automatic tick(input int rem, input logic b, input logic e);
    bus.one_hz_enable = 1'b1;
    expect_at(1, rem, b, e, 1'b0);
    step();
    bus.one_hz_enable = 1'b0;
  endtask

  initial begin
    bus.start_timer   = 1'b0;
    bus.value         = '0;
    bus.abort         = 1'b0;
    bus.one_hz_enable = 1'b0;

    // Reset state, then ticks in IDLE leave everything at zero.
    idle(2);
    tid = 0;
    expect_at(0, 0, 0, 0, 0);
    step();
    reset_n = 1'b1;
    tick(0, 0, 0);

    // Load 5, tick every 10 cycles.
    tid = 1;
    load(5, 1, 0);
    for (int i = 1; i <= 5; i++) begin
      idle(9);
      tick(5 - i, (i < 5), (i == 5));
    end
    expect_at(1, 0, 0, 0, 0);
    step();
    tick(0, 0, 0);

    // Reload mid-count.
    tid = 2;
    load(9, 1, 0);
    for (int i = 1; i <= 4; i++) begin
      idle(3);
      tick(9 - i, 1, 0);
    end
    idle(2);
    load(3, 1, 0);
    idle(3); tick(2, 1, 0);
    idle(3); tick(1, 1, 0);
    idle(3); tick(0, 0, 1);
    expect_at(1, 0, 0, 0, 0);
    step();

    // Zero load goes straight to DONE; a tick in DONE is ignored.
    tid = 3;
    idle(2);
    load(0, 0, 1);
    tick(0, 0, 0);
    idle(2);

    // Abort mid-count, then abort while idle.
    tid = 4;
    load(6, 1, 0);
    idle(2); tick(5, 1, 0);
    idle(2); tick(4, 1, 0);
    idle(2);
    bus.abort = 1'b1;
    expect_at(1, 0, 0, 0, 0);
    step();
    bus.abort = 1'b0;
    tick(0, 0, 0);
    idle(2);
    tick(0, 0, 0);
    bus.abort = 1'b1;
    expect_at(1, 0, 0, 0, 0);
    step();
    bus.abort = 1'b0;

    // Asynchronous reset between ticks.
    tid = 5;
    load(4, 1, 0);
    idle(2); tick(3, 1, 0);
    idle(2);
    #1 reset_n = 1'b0;
    expect_at(0, 0, 0, 0, 0);
    step();
    expect_at(0, 0, 0, 0, 0);
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      idle(2);
      tick(0, 0, 0);
    end

    // Start coincident with tick, and start coincident with abort.
    tid = 6;
    load(5, 1, 0);
    idle(2); tick(4, 1, 0);
    bus.start_timer   = 1'b1;
    bus.value         = 4'd2;
    bus.one_hz_enable = 1'b1;
    expect_at(1, 2, 1, 0, 1);
    step();
    bus.start_timer   = 1'b0;
    bus.one_hz_enable = 1'b0;
    idle(3); tick(1, 1, 0);
    idle(3); tick(0, 0, 1);
    expect_at(1, 0, 0, 0, 0);
    step();
    load(7, 1, 0);
    idle(2);
    bus.start_timer = 1'b1;
    bus.value       = 4'd2;
    bus.abort       = 1'b1;
    expect_at(1, 2, 1, 0, 1);
    step();
    bus.start_timer = 1'b0;
    bus.abort       = 1'b0;
    idle(2); tick(1, 1, 0);
    idle(2); tick(0, 0, 1);
    step();

    // Maximum load, and a reload issued during the DONE cycle.
    tid = 7;
    load(15, 1, 0);
    tick(14, 1, 0);
    tick(13, 1, 0);
    load(1, 1, 0);
    tick(0, 0, 1);
    load(2, 1, 0);
    idle(1); tick(1, 1, 0);
    idle(1); tick(0, 0, 1);
    expect_at(1, 0, 0, 0, 0);
    step();

    for (int i = 0; i < 20 && sb_q.size() > 0; i++) step();
    if (sb_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain actual pending=%0d required pending=0", sb_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
